fetch_sequencer: RTL and testbench

Owns the architectural program counter of the 8-bit-PC RISC-V core and decides its next value every cycle. It chooses between sequential advance, taken branch/jump redirect, trap entry and trap return. It sits between the combinational PC incrementer, the instruction memory/fetch stage and the PMP checker. It stalls on back-pressure and enters a trap on PMP fetch faults or misaligned targets.

---
 rtl/fetch_sequencer_pkg.sv | 23 ++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, trap cause
// codes and the default reset/trap vectors.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  localparam logic [1:0] CAUSE_MISALIGNED = 2'd0;
  localparam logic [1:0] CAUSE_ACCESS     = 2'd1;

  localparam logic [7:0] DEF_RESET_VEC = 8'h00;
  localparam logic [7:0] DEF_TRAP_VEC  = 8'hF0;

  // A fetch target is legal only when it is word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Architectural PC owner: picks sequential advance, redirect, trap entry or
// trap return each cycle, and stops the core on a fault inside the handler.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [PC_W-1:0] TRAP_VEC  = DEF_TRAP_VEC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc_out,
  input  logic [PC_W-1:0] pc_inc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            pmp_fetch_fault,
  input  logic            mret,
  output logic            trap_active,
  output logic [PC_W-1:0] mepc,
  output logic [1:0]      mcause,
  output logic            halted
);

  fetch_state_t    state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [PC_W-1:0] mepc_r, mepc_s;
  logic [1:0]      mcause_r, mcause_s;
  logic            trap_active_r, trap_active_s;
  logic            fetch_valid_r;
  logic            halted_r;

  // Next-state and next-PC selection; RUN resolves events by fixed priority.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    mepc_s        = mepc_r;
    mcause_s      = mcause_r;
    trap_active_s = trap_active_r;
    case (state_r)
      ST_BOOT: begin
        state_s = ST_RUN;
      end
      ST_RUN: begin
        if (pmp_fetch_fault) begin
          mepc_s   = pc_r;
          mcause_s = CAUSE_ACCESS;
          state_s  = ST_TRAP;
        end else if (redirect_valid && is_misaligned(redirect_target[1:0])) begin
          mepc_s   = redirect_target;
          mcause_s = CAUSE_MISALIGNED;
          state_s  = ST_TRAP;
        end else if (redirect_valid) begin
          pc_s = redirect_target;
        end else if (mret && trap_active_r) begin
          pc_s          = mepc_r;
          trap_active_s = 1'b0;
        end else if (fetch_ready) begin
          pc_s = pc_inc;
        end else begin
          pc_s = pc_r;
        end
      end
      ST_TRAP: begin
        if (trap_active_r) begin
          state_s = ST_HALT;
        end else begin
          pc_s          = TRAP_VEC;
          trap_active_s = 1'b1;
          state_s       = ST_RUN;
        end
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        state_s = ST_BOOT;
      end
    endcase
  end

  // State and architectural registers; status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_VEC;
      mepc_r        <= {PC_W{1'b0}};
      mcause_r      <= 2'd0;
      trap_active_r <= 1'b0;
      fetch_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      mepc_r        <= mepc_s;
      mcause_r      <= mcause_s;
      trap_active_r <= trap_active_s;
      fetch_valid_r <= (state_s == ST_RUN);
      halted_r      <= (state_s == ST_HALT);
    end
  end

  assign pc_out      = pc_r;
  assign mepc        = mepc_r;
  assign mcause      = mcause_r;
  assign trap_active = trap_active_r;
  assign fetch_valid = fetch_valid_r;
  assign halted      = halted_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the PC rules.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc_out;
  logic [7:0] pc_inc;
  logic       fetch_valid;
  logic       fetch_ready;
  logic       redirect_valid;
  logic [7:0] redirect_target;
  logic       pmp_fetch_fault;
  logic       mret;
  logic       trap_active;
  logic [7:0] mepc;
  logic [1:0] mcause;
  logic       halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, in architectural terms.
  logic [7:0] m_pc;
  logic [7:0] m_mepc;
  logic [1:0] m_mcause;
  bit         m_handler;
  bit         m_booting;
  bit         m_trap_cycle;
  bit         m_halted;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_out         (pc_out),
    .pc_inc         (pc_inc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .pmp_fetch_fault(pmp_fetch_fault),
    .mret           (mret),
    .trap_active    (trap_active),
    .mepc           (mepc),
    .mcause         (mcause),
    .halted         (halted)
  );

  // External incrementer.
  assign pc_inc = pc_out + 8'd4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},          pc_out,                m_pc);
    check({tag, ".fetch_valid"}, {7'd0, fetch_valid},   {7'd0, !(m_booting || m_trap_cycle || m_halted)});
    check({tag, ".trap_active"}, {7'd0, trap_active},   {7'd0, m_handler});
    check({tag, ".mepc"},        mepc,                  m_mepc);
    check({tag, ".mcause"},      {6'd0, mcause},        {6'd0, m_mcause});
    check({tag, ".halted"},      {7'd0, halted},        {7'd0, m_halted});
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_mepc = 8'h00; m_mcause = 2'd0;
    m_handler = 1'b0; m_booting = 1'b1; m_trap_cycle = 1'b0; m_halted = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_clock();
    if (m_halted) begin
      // frozen until reset
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_trap_cycle) begin
      m_trap_cycle = 1'b0;
      if (m_handler) m_halted = 1'b1;
      else begin m_pc = 8'hF0; m_handler = 1'b1; end
    end else if (pmp_fetch_fault) begin
      m_mepc = m_pc; m_mcause = 2'd1; m_trap_cycle = 1'b1;
    end else if (redirect_valid && (redirect_target % 4 != 0)) begin
      m_mepc = redirect_target; m_mcause = 2'd0; m_trap_cycle = 1'b1;
    end else if (redirect_valid) begin
      m_pc = redirect_target;
    end else if (mret && m_handler) begin
      m_pc = m_mepc; m_handler = 1'b0;
    end else if (fetch_ready) begin
      m_pc = 8'((m_pc + 9'd4) % 256);
    end
  endtask

  task automatic drive(input bit rdy, input bit rv, input logic [7:0] tgt, input bit pmp, input bit mr);
    fetch_ready = rdy; redirect_valid = rv; redirect_target = tgt;
    pmp_fetch_fault = pmp; mret = mr;
  endtask

  task automatic step(input string tag);
    model_clock();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Sequential fetch 00,04,08 then stall at 08 and resume to 0C.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("boot_exit");
    step("seq04");
    step("seq08");
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("stall");
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("seq0c");

    // Aligned redirect without ready, then misaligned redirect trap.
    drive(1'b0, 1'b1, 8'h40, 1'b0, 1'b0);
    step("redir40");
    drive(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
    step("mis_fault");
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("mis_trapcyc");
    step("mis_vec");
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step("mret42");

    // Fault together with redirect at 20, then mret back to 20.
    drive(1'b0, 1'b1, 8'h20, 1'b0, 1'b0);
    step("redir20");
    drive(1'b1, 1'b1, 8'h80, 1'b1, 1'b0);
    step("pmp_fault");
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("pmp_trapcyc");
    step("pmp_vec");
    step("handler_seq");
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step("mret20");
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    step("mret_ignored");

    // Fault inside handler leads to halt.
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step("f1");
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("f1_trap");
    step("f1_vec");
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step("f2");
    drive(1'b1, 1'b1, 8'h10, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step("halt");
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("restart");
    step("restart04");

    // Wrap from FC to 00.
    drive(1'b0, 1'b1, 8'hFC, 1'b0, 1'b0);
    step("redirFC");
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("wrap00");

    // Reset asserted mid-TRAP.
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step("pre_trap");
    do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step("post_trap_reset");

    // Randomized traffic.
    begin
      int halt_cnt = 0;
      for (int i = 0; i < 400; i++) begin
        logic [7:0] t;
        t = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, t,
              $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0);
        step("rand");
        if (m_halted) halt_cnt++;
        if (halt_cnt > 3 || $urandom_range(0, 149) == 0) begin
          halt_cnt = 0;
          do_reset();
        end
      end
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
